// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues single-word reads and hands captured words to decode.
// Optional feature: define FETCH_PERF_EN to add the perf_fetched / perf_stall_cycles counters.
module fetch_unit #(
   parameter logic [31:0] base_addr = 32'h80020000,
   parameter logic [31:0] reset_pc  = 32'h80020000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        fetch_en,
   input  logic        stall,
   input  logic        pc_load,
   input  logic [31:0] pc_target,
   output logic [31:0] mem_address,
   output logic [1:0]  mem_access_size,
   output logic        mem_rw,
   output logic        mem_enable,
   input  logic [31:0] mem_data_in,
   output logic [31:0] insn,
   output logic [31:0] insn_pc,
   output logic        insn_valid
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stall_cycles
`endif
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      HOLD    = 2'd3
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] pc;
   logic        capture;
   logic        accept;

   // base_addr only documents the memory map; it has no effect on the logic.
   logic unused_cfg;
   assign unused_cfg = ^base_addr;

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (fetch_en) begin
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            state_next = CAPTURE;
         end
         CAPTURE: begin
            capture    = 1'b1;
            state_next = HOLD;
         end
         HOLD: begin
            if (!stall) begin
               accept     = 1'b1;
               state_next = fetch_en ? ISSUE : IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      // A redirect discards any in-flight or presented word and refetches from the new PC.
      if (pc_load) begin
         capture    = 1'b0;
         accept     = 1'b0;
         state_next = ISSUE;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc      <= reset_pc;
         insn    <= 32'h0;
         insn_pc <= 32'h0;
      end else if (pc_load) begin
         pc <= pc_target & ~32'h3;
      end else if (capture) begin
         insn    <= mem_data_in;
         insn_pc <= pc;
         pc      <= pc + 32'd4;
      end
   end

   assign mem_address     = pc;
   assign mem_access_size = 2'b00;
   assign mem_rw          = 1'b1;
   assign mem_enable      = (state == ISSUE);
   assign insn_valid      = (state == HOLD);

`ifdef FETCH_PERF_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         perf_fetched      <= 32'h0;
         perf_stall_cycles <= 32'h0;
      end else begin
         if (accept) begin
            perf_fetched <= perf_fetched + 32'd1;
         end
         if (state == HOLD && stall) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
         end
      end
   end
`else
   logic unused_accept;
   assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected reads and accepted words are queued by the stimulus
// and popped by a negedge monitor; a second instance with reset_pc=32'hFFFFFFFC covers PC wrap.
module tb_fetch_unit;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset, fetch_en, stall, pc_load;
   logic [31:0] pc_target;
   logic [31:0] mem_address;
   logic [1:0]  mem_access_size;
   logic        mem_rw, mem_enable;
   logic [31:0] mem_data_in = 32'h0;
   logic [31:0] insn, insn_pc;
   logic        insn_valid;

   logic        reset2, fetch_en2;
   logic        stall2     = 1'b0;
   logic        pc_load2   = 1'b0;
   logic [31:0] pc_target2 = 32'h0;
   logic [31:0] mem_address2;
   logic [1:0]  mem_access_size2;
   logic        mem_rw2, mem_enable2;
   logic [31:0] mem_data_in2 = 32'h0;
   logic [31:0] insn2, insn_pc2;
   logic        insn_valid2;

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched, perf_stall_cycles, perf_fetched2, perf_stall_cycles2;
`endif

   fetch_unit u_dut (
      .clock(clock), .reset(reset), .fetch_en(fetch_en), .stall(stall),
      .pc_load(pc_load), .pc_target(pc_target),
      .mem_address(mem_address), .mem_access_size(mem_access_size), .mem_rw(mem_rw),
      .mem_enable(mem_enable), .mem_data_in(mem_data_in),
      .insn(insn), .insn_pc(insn_pc), .insn_valid(insn_valid)
`ifdef FETCH_PERF_EN
      , .perf_fetched(perf_fetched), .perf_stall_cycles(perf_stall_cycles)
`endif
   );

   fetch_unit #(.reset_pc(32'hFFFFFFFC)) u_wrap (
      .clock(clock), .reset(reset2), .fetch_en(fetch_en2), .stall(stall2),
      .pc_load(pc_load2), .pc_target(pc_target2),
      .mem_address(mem_address2), .mem_access_size(mem_access_size2), .mem_rw(mem_rw2),
      .mem_enable(mem_enable2), .mem_data_in(mem_data_in2),
      .insn(insn2), .insn_pc(insn_pc2), .insn_valid(insn_valid2)
`ifdef FETCH_PERF_EN
      , .perf_fetched(perf_fetched2), .perf_stall_cycles(perf_stall_cycles2)
`endif
   );

   int checks   = 0;
   int failures = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Byte-addressed memory contents; the first word is the known instruction 8F BF 00 10.
   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      case (a)
         32'h80020000: return 8'h8F;
         32'h80020001: return 8'hBF;
         32'h80020002: return 8'h00;
         32'h80020003: return 8'h10;
         default:      return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
      endcase
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {mem_byte(a), mem_byte(a + 32'd1), mem_byte(a + 32'd2), mem_byte(a + 32'd3)};
   endfunction

   always @(posedge clock) begin
      if (mem_enable === 1'b1) mem_data_in <= mem_word(mem_address);
      if (mem_enable2 === 1'b1) mem_data_in2 <= mem_word(mem_address2);
   end

   typedef struct {
      logic [31:0] word;
      logic [31:0] pc;
   } insn_exp_t;

   logic [31:0] exp_addr_q[$];
   insn_exp_t   exp_insn_q[$];
   insn_exp_t   mon_e;

   always @(negedge clock) begin
      if (mem_enable === 1'b1) begin
         if (exp_addr_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL issue_addr: got unexpected read at %h expected none", mem_address);
         end else begin
            check32("issue_addr", mem_address, exp_addr_q.pop_front());
         end
      end
      if (insn_valid === 1'b1 && stall === 1'b0 && pc_load === 1'b0) begin
         if (exp_insn_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL accept: got unexpected word %h at %h expected none", insn, insn_pc);
         end else begin
            mon_e = exp_insn_q.pop_front();
            check32("accept_insn", insn, mon_e.word);
            check32("accept_pc", insn_pc, mon_e.pc);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic expect_word(input logic [31:0] a);
      exp_addr_q.push_back(a);
      exp_insn_q.push_back('{mem_word(a), a});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; fetch_en = 1'b0; stall = 1'b0; pc_load = 1'b0; pc_target = 32'h0;
      reset2 = 1'b1; fetch_en2 = 1'b0;
      tick();
      tick();
      check32("rst_valid", insn_valid, 0);
      check32("rst_enable", mem_enable, 0);
      check32("rst_addr", mem_address, 32'h80020000);
      check32("rst_size", mem_access_size, 0);
      check32("rst_rw", mem_rw, 1);
      check32("rst_insn", insn, 0);
      check32("rst_insn_pc", insn_pc, 0);
`ifdef FETCH_PERF_EN
      check32("rst_perf_fetched", perf_fetched, 0);
      check32("rst_perf_stall", perf_stall_cycles, 0);
`endif
      reset = 1'b0;

      // Single fetch followed by five stalled HOLD cycles.
      expect_word(32'h80020000);
      fetch_en = 1'b1; stall = 1'b1;
      tick();
      fetch_en = 1'b0;
      check32("issue_enable", mem_enable, 1);
      check32("issue_rw", mem_rw, 1);
      tick();
      check32("capture_valid", insn_valid, 0);
      check32("capture_enable", mem_enable, 0);
      tick();
      check32("hold_valid", insn_valid, 1);
      check32("hold_insn", insn, 32'h8FBF0010);
      check32("hold_insn_pc", insn_pc, 32'h80020000);
      for (int i = 0; i < 5; i++) begin
         tick();
         check32("stall_valid", insn_valid, 1);
         check32("stall_insn", insn, 32'h8FBF0010);
         check32("stall_insn_pc", insn_pc, 32'h80020000);
         check32("stall_enable", mem_enable, 0);
      end

      // Release: next ISSUE at +4, then redirect during CAPTURE discards that word.
      exp_addr_q.push_back(32'h80020004);
      stall = 1'b0; fetch_en = 1'b1;
      tick();
      fetch_en = 1'b0;
      check32("next_issue_addr", mem_address, 32'h80020004);
      check32("next_issue_valid", insn_valid, 0);
`ifdef FETCH_PERF_EN
      check32("perf_stall_5", perf_stall_cycles, 5);
`endif
      tick();
      expect_word(32'h80020100);
      pc_load = 1'b1; pc_target = 32'h80020103;
      tick();
      pc_load = 1'b0;
      check32("redir_valid", insn_valid, 0);
      check32("redir_addr", mem_address, 32'h80020100);
      tick();
      check32("redir_capture_valid", insn_valid, 0);
      tick();
      check32("redir_hold_pc", insn_pc, 32'h80020100);
      tick();
      check32("redir_idle_valid", insn_valid, 0);

      // Streaming four words from the base address.
      pc_load = 1'b1; pc_target = 32'h80020000;
      for (int i = 0; i < 4; i++) expect_word(32'h80020000 + 32'(4 * i));
      tick();
      pc_load = 1'b0; fetch_en = 1'b1;
`ifdef FETCH_PERF_EN
      check32("perf_before_stream", perf_fetched, 2);
`endif
      repeat (11) tick();
      fetch_en = 1'b0;
      check32("stream_last_pc", insn_pc, 32'h8002000C);
      tick();
      check32("stream_idle_valid", insn_valid, 0);
      check32("stream_idle_enable", mem_enable, 0);
`ifdef FETCH_PERF_EN
      check32("perf_stream", perf_fetched, 6);
`endif

      // Redirect in HOLD with stall=0 withdraws the presented word.
      exp_addr_q.push_back(32'h80020010);
      fetch_en = 1'b1;
      tick();
      fetch_en = 1'b0;
      tick();
      tick();
      check32("hold_redir_pc", insn_pc, 32'h80020010);
      expect_word(32'h80020200);
      pc_load = 1'b1; pc_target = 32'h80020200;
      tick();
      pc_load = 1'b0;
      check32("hold_redir_valid", insn_valid, 0);
      tick();
      tick();
      check32("hold_redir_new_pc", insn_pc, 32'h80020200);
      tick();
`ifdef FETCH_PERF_EN
      check32("perf_withdrawn", perf_fetched, 7);
`endif

      // Reset asserted during ISSUE aborts the read.
      exp_addr_q.push_back(32'h80020204);
      fetch_en = 1'b1;
      tick();
      fetch_en = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check32("midrst_valid", insn_valid, 0);
      check32("midrst_enable", mem_enable, 0);
      check32("midrst_addr", mem_address, 32'h80020000);
      check32("midrst_insn", insn, 0);
      tick();
      check32("midrst_idle_valid", insn_valid, 0);
      expect_word(32'h80020000);
      fetch_en = 1'b1;
      tick();
      fetch_en = 1'b0;
      tick();
      tick();
      check32("postrst_insn", insn, 32'h8FBF0010);
      tick();

      // PC wrap on the second instance.
      check32("wrap_rst_addr", mem_address2, 32'hFFFFFFFC);
      reset2 = 1'b0; fetch_en2 = 1'b1;
      tick();
      check32("wrap_issue1_addr", mem_address2, 32'hFFFFFFFC);
      check32("wrap_issue1_enable", mem_enable2, 1);
      tick();
      tick();
      check32("wrap_hold1_valid", insn_valid2, 1);
      check32("wrap_hold1_pc", insn_pc2, 32'hFFFFFFFC);
      check32("wrap_hold1_insn", insn2, mem_word(32'hFFFFFFFC));
      tick();
      fetch_en2 = 1'b0;
      check32("wrap_issue2_addr", mem_address2, 32'h00000000);
      check32("wrap_issue2_enable", mem_enable2, 1);
      tick();
      tick();
      check32("wrap_hold2_pc", insn_pc2, 32'h00000000);
      check32("wrap_hold2_insn", insn2, mem_word(32'h00000000));
      tick();
      check32("wrap_idle_valid", insn_valid2, 0);

      tick();
      check32("addr_q_drained", exp_addr_q.size(), 0);
      check32("insn_q_drained", exp_insn_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
